// File: rtl/up_down_count_monitor_pkg.sv
// Shared widths, FSM state encoding and step-class encoding for the
// up/down count monitor family.
package up_down_count_monitor_pkg;

    localparam int CNT_W = 3;
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = 4'd15;
    localparam logic [RUN_W-1:0] RUN_ONE = 4'd1;

    typedef enum logic [2:0] {
        ST_EMPTY     = 3'd0,
        ST_FIRST     = 3'd1,
        ST_LOCK_UP   = 3'd2,
        ST_LOCK_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_BAD  = 2'd3
    } step_t;

endpackage

// File: rtl/up_down_count_monitor_count_step_decoder.sv
// Classifies one counter step (prev -> q) as UP/DOWN/HOLD/BAD and flags a
// modular wrap. Width comes from the parameter so wider monitors can reuse it.
module count_step_decoder
    import up_down_count_monitor_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] q,
    output logic [1:0]   step,
    output logic         wrap
);

    logic [W-1:0] delta;

    // delta is taken modulo 2**W, so all-ones means a single step down.
    always_comb begin
        delta = q - prev;
        step  = STEP_BAD;
        if (delta == {{(W-1){1'b0}}, 1'b1})
            step = STEP_UP;
        else if (delta == {W{1'b1}})
            step = STEP_DOWN;
        else if (delta == {W{1'b0}})
            step = STEP_HOLD;
        wrap = ((step == STEP_UP) && (prev == {W{1'b1}})) ||
               ((step == STEP_DOWN) && (prev == {W{1'b0}}));
    end

endmodule

// File: rtl/up_down_count_monitor.sv
// Receive-side checker for a 3-bit up/down counter stream: recovers direction,
// flags wrap/reversal/illegal steps and tracks a saturating run length.
module up_down_count_monitor
    import up_down_count_monitor_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             valid,
    input  logic [CNT_W-1:0] q,
    output logic             mode,
    output logic             locked,
    output logic             wrap,
    output logic             rev,
    output logic             err,
    output logic             err_sticky,
    output logic [RUN_W-1:0] run_len,
    output logic [2:0]       fsm_state
);

    // valid is a one-way strobe with no backpressure: q is consumed on every
    // rising edge where valid=1; edges with valid=0 leave all state untouched.

    state_t           state, state_n;
    logic [CNT_W-1:0] prev;
    logic [1:0]       step;
    logic             step_wrap;
    logic             mode_n, wrap_n, rev_n, err_n, sticky_n;
    logic [RUN_W-1:0] run_n, run_inc;

    count_step_decoder #(.W(CNT_W)) u_dec (
        .prev (prev),
        .q    (q),
        .step (step),
        .wrap (step_wrap)
    );

    assign run_inc   = (run_len == RUN_MAX) ? run_len : run_len + 1'b1;
    assign locked    = (state == ST_LOCK_UP) || (state == ST_LOCK_DOWN);
    assign fsm_state = state;

    always_comb begin
        state_n  = state;
        mode_n   = mode;
        wrap_n   = 1'b0;
        rev_n    = 1'b0;
        err_n    = 1'b0;
        sticky_n = err_sticky;
        run_n    = run_len;
        if (valid) begin
            case (state)
                ST_EMPTY: state_n = ST_FIRST;
                ST_FIRST, ST_LOCK_UP, ST_LOCK_DOWN: begin
                    case (step)
                        STEP_UP: begin
                            state_n = ST_LOCK_UP;
                            mode_n  = 1'b1;
                            wrap_n  = step_wrap;
                            rev_n   = (state == ST_LOCK_DOWN);
                            run_n   = (state == ST_LOCK_UP) ? run_inc : RUN_ONE;
                        end
                        STEP_DOWN: begin
                            state_n = ST_LOCK_DOWN;
                            mode_n  = 1'b0;
                            wrap_n  = step_wrap;
                            rev_n   = (state == ST_LOCK_UP);
                            run_n   = (state == ST_LOCK_DOWN) ? run_inc : RUN_ONE;
                        end
                        STEP_HOLD: begin
                        end
                        default: begin
                            state_n  = ST_FAULT;
                            err_n    = 1'b1;
                            sticky_n = 1'b1;
                            run_n    = '0;
                        end
                    endcase
                end
                // Resync: the sample leaving FAULT only re-primes prev.
                ST_FAULT: begin
                    state_n = ST_FIRST;
                    run_n   = '0;
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= ST_EMPTY;
            prev       <= '0;
            mode       <= 1'b0;
            wrap       <= 1'b0;
            rev        <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            run_len    <= '0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            wrap       <= wrap_n;
            rev        <= rev_n;
            err        <= err_n;
            err_sticky <= sticky_n;
            run_len    <= run_n;
            if (valid)
                prev <= q;
        end
    end

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Scoreboard bench for up_down_count_monitor: directed sample streams push
// hand-computed responses; a negedge monitor pops and compares them.
module tb_up_down_count_monitor;
    import up_down_count_monitor_pkg::*;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] q = 3'd0;
    logic       mode, locked, wrap, rev, err, err_sticky;
    logic [3:0] run_len;
    logic [2:0] fsm_state;

    // Response word: {mode, locked, wrap, rev, err, err_sticky, run_len}
    localparam logic [9:0] IDLE_MASK = 10'b11_0001_1111;

    logic [9:0] exp_q[$];
    logic [9:0] last_exp = '0;
    logic [9:0] act;
    logic       pend = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    string      cur_test = "reset";

    up_down_count_monitor dut (
        .clock      (clock),
        .clear      (clear),
        .valid      (valid),
        .q          (q),
        .mode       (mode),
        .locked     (locked),
        .wrap       (wrap),
        .rev        (rev),
        .err        (err),
        .err_sticky (err_sticky),
        .run_len    (run_len),
        .fsm_state  (fsm_state)
    );

    always #5 clock = ~clock;

    assign act = {mode, locked, wrap, rev, err, err_sticky, run_len};

    function automatic logic [9:0] e(input logic m, input logic l, input logic w,
                                     input logic r, input logic er, input logic s,
                                     input logic [3:0] rl);
        return {m, l, w, r, er, s, rl};
    endfunction

    task automatic check(input string nm, input logic [9:0] a, input logic [9:0] x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s/%s: got mode,locked,wrap,rev,err,sticky,run=%b required %b at %0t",
                     cur_test, nm, a, x, $time);
        end
    endtask

    // A sample accepted at edge N is answered in the half-cycle after edge N.
    always @(posedge clock or negedge clear) begin
        if (!clear) pend <= 1'b0;
        else        pend <= valid;
    end

    always @(negedge clock) begin : monitor
        logic [9:0] x;
        if (!clear) begin
            last_exp = '0;
        end else if (pend) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s/unexpected: got %b required no response at %0t",
                         cur_test, act, $time);
            end else begin
                x = exp_q.pop_front();
                check("sample", act, x);
                last_exp = x;
            end
        end else begin
            check("idle", act, last_exp & IDLE_MASK);
        end
    end

    task automatic send(input logic [2:0] v, input logic [9:0] x);
        @(posedge clock);
        #1;
        valid = 1'b1;
        q     = v;
        exp_q.push_back(x);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            valid = 1'b0;
            q     = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s/drain: got %0d outstanding required 0", cur_test, exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic reset_dut(input logic do_check);
        gap(2);
        drain();
        @(posedge clock);
        #3;
        clear = 1'b0;
        #1;
        if (do_check) begin
            check("async_reset", act, '0);
            n_cmp++;
            if (fsm_state !== ST_EMPTY) begin
                n_bad++;
                $display("FAIL %s/reset_state: got %0d required %0d", cur_test, fsm_state, ST_EMPTY);
            end
        end
        @(posedge clock);
        #3;
        clear = 1'b1;
    endtask

    initial begin
        logic [3:0] rl;
        #12 clear = 1'b1;

        cur_test = "up_stream";
        send(3'd5, e(0, 0, 0, 0, 0, 0, 4'd0));
        send(3'd6, e(1, 1, 0, 0, 0, 0, 4'd1));
        send(3'd7, e(1, 1, 0, 0, 0, 0, 4'd2));
        send(3'd0, e(1, 1, 1, 0, 0, 0, 4'd3));
        send(3'd1, e(1, 1, 0, 0, 0, 0, 4'd4));

        reset_dut(1'b0);
        cur_test = "down_stalls";
        send(3'd2, e(0, 0, 0, 0, 0, 0, 4'd0)); gap(3);
        send(3'd1, e(0, 1, 0, 0, 0, 0, 4'd1)); gap(3);
        send(3'd0, e(0, 1, 0, 0, 0, 0, 4'd2)); gap(3);
        send(3'd7, e(0, 1, 1, 0, 0, 0, 4'd3)); gap(3);

        reset_dut(1'b0);
        cur_test = "reversal";
        send(3'd3, e(0, 0, 0, 0, 0, 0, 4'd0));
        send(3'd4, e(1, 1, 0, 0, 0, 0, 4'd1));
        send(3'd5, e(1, 1, 0, 0, 0, 0, 4'd2));
        send(3'd4, e(0, 1, 0, 1, 0, 0, 4'd1));
        send(3'd3, e(0, 1, 0, 0, 0, 0, 4'd2));

        reset_dut(1'b0);
        cur_test = "illegal";
        send(3'd1, e(0, 0, 0, 0, 0, 0, 4'd0));
        send(3'd2, e(1, 1, 0, 0, 0, 0, 4'd1));
        send(3'd5, e(1, 0, 0, 0, 1, 1, 4'd0));
        gap(2);
        send(3'd6, e(1, 0, 0, 0, 0, 1, 4'd0));
        send(3'd7, e(1, 1, 0, 0, 0, 1, 4'd1));
        send(3'd0, e(1, 1, 1, 0, 0, 1, 4'd2));
        send(3'd7, e(0, 1, 1, 1, 0, 1, 4'd1));

        reset_dut(1'b0);
        cur_test = "saturate";
        send(3'd0, e(0, 0, 0, 0, 0, 0, 4'd0));
        send(3'd0, e(0, 0, 0, 0, 0, 0, 4'd0));
        for (int i = 1; i <= 17; i++) begin
            rl = (i > 15) ? 4'd15 : 4'(i);
            send(3'(i), e(1, 1, (i % 8 == 0), 0, 0, 0, rl));
            send(3'(i), e(1, 1, 0, 0, 0, 0, rl));
        end

        cur_test = "async_reset";
        reset_dut(1'b1);
        send(3'd7, e(0, 0, 0, 0, 0, 0, 4'd0));
        send(3'd6, e(0, 1, 0, 0, 0, 0, 4'd1));
        gap(2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
